// File: rtl/vram_write_scheduler_if.sv
// rtl/vram_write_scheduler_if.sv - CPU-side write/flush bus of the VRAM write scheduler
interface vram_write_scheduler_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          cpu_valid;
    logic          cpu_ready;
    logic          cpu_sel;
    logic [13:0]   cpu_addr;
    logic [31:0]   cpu_data;
    logic          cpu_flush;
    logic          flush_done;
    logic [LW-1:0] fifo_level;

    modport master (
        output cpu_valid, cpu_sel, cpu_addr, cpu_data, cpu_flush,
        input  cpu_ready, flush_done, fifo_level
    );

    modport slave (
        input  cpu_valid, cpu_sel, cpu_addr, cpu_data, cpu_flush,
        output cpu_ready, flush_done, fifo_level
    );
endinterface

// File: rtl/vram_write_scheduler.sv
// rtl/vram_write_scheduler.sv - buffers CPU VRAM8/VRAM32 writes and commits them in blanking slots
// Optional: define VRAM_VBLANK_ONLY_EN to commit only during vertical blanking.
module vram_write_scheduler #(
    parameter int DEPTH     = 16,
    parameter int VSTART    = 86,
    parameter int VLINES    = 400,
    parameter int WIN_START = 4,
    parameter int WIN_END   = 124
) (
    input  logic                    clkPixel,
    input  logic                    reset,
    input  logic [11:0]             h_count,
    input  logic [11:0]             v_count,
    vram_write_scheduler_if.slave   cpu,
    input  logic [13:0]             render_vram8_addr,
    input  logic [10:0]             render_vram32_addr,
    output logic [13:0]             vram8_addr,
    output logic [7:0]              vram8_d,
    output logic                    vram8_we,
    output logic [10:0]             vram32_addr,
    output logic [31:0]             vram32_d,
    output logic                    vram32_we
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [11:0] V_FIRST = 12'(VSTART - 1);
    localparam logic [11:0] V_END   = 12'(VSTART - 1 + VLINES);
    localparam logic [11:0] H_OPEN  = 12'(WIN_START);
`ifndef VRAM_VBLANK_ONLY_EN
    localparam logic [11:0] H_CLOSE = 12'(WIN_END);
`endif

    typedef struct packed {
        logic        sel;
        logic [13:0] addr;
        logic [31:0] data;
    } entry_t;

    typedef enum logic {IDLE, DRAIN} state_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic          push;
    logic          commit;
    logic          done;
    logic          flush_pending;
    logic          vblank;
    logic          slot;
    state_t        state_q;
    state_t        state_d;

    // Extra pointer bit separates full (MSBs differ) from empty (all equal).
    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = cpu.cpu_valid && !full;
    assign head  = mem[rd_ptr[AW-1:0]];

    assign cpu.cpu_ready  = !full;
    assign cpu.fifo_level = level;
    assign cpu.flush_done = done;

    always_comb begin
        vblank = (v_count < V_FIRST) || (v_count >= V_END);
`ifdef VRAM_VBLANK_ONLY_EN
        slot = vblank && (h_count >= H_OPEN);
`else
        slot = vblank ? (h_count >= H_OPEN)
                      : ((h_count >= H_OPEN) && (h_count < H_CLOSE));
`endif
    end

    // Entering DRAIN commits in the same cycle, so a push in cycle N can land in N+1.
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (slot && !empty) begin
                    commit  = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (slot && !empty) begin
                    commit = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit && (level == LW'(1)) && !push) begin
            state_d = IDLE;
        end
        if (reset) begin
            commit  = 1'b0;
            state_d = IDLE;
        end
    end

    always_comb begin
        vram8_addr  = render_vram8_addr;
        vram32_addr = render_vram32_addr;
        vram8_we    = 1'b0;
        vram32_we   = 1'b0;
        vram8_d     = '0;
        vram32_d    = '0;
        if (commit) begin
            if (head.sel) begin
                vram32_we   = 1'b1;
                vram32_addr = head.addr[10:0];
                vram32_d    = head.data;
            end else begin
                vram8_we   = 1'b1;
                vram8_addr = head.addr;
                vram8_d    = head.data[7:0];
            end
        end
    end

    // A push in the same cycle means the FIFO is not really drained yet.
    assign done = flush_pending && empty && !push && !reset;

    always_ff @(posedge clkPixel) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            state_q       <= IDLE;
            flush_pending <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (commit) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            state_q       <= state_d;
            flush_pending <= (flush_pending || cpu.cpu_flush) && !done;
        end
    end

    always_ff @(posedge clkPixel) begin
        if (push && !reset) begin
            mem[wr_ptr[AW-1:0]] <= '{sel: cpu.cpu_sel, addr: cpu.cpu_addr, data: cpu.cpu_data};
        end
    end

    assert property (@(posedge clkPixel) disable iff (reset) !(vram8_we && vram32_we));
    assert property (@(posedge clkPixel) disable iff (reset) !(push && full));
endmodule

// File: tb/tb_vram_write_scheduler.sv
// tb/tb_vram_write_scheduler.sv - self-checking bench for vram_write_scheduler
module tb_vram_write_scheduler;
    localparam int DEPTH = 16, VSTART = 86, VLINES = 400, WIN_START = 4, WIN_END = 124;
    localparam int LW = $clog2(DEPTH) + 1;

    logic        clkPixel = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] h_count = '0;
    logic [11:0] v_count = '0;
    logic [13:0] render_vram8_addr = '0;
    logic [10:0] render_vram32_addr = '0;
    logic [13:0] vram8_addr;
    logic [7:0]  vram8_d;
    logic        vram8_we;
    logic [10:0] vram32_addr;
    logic [31:0] vram32_d;
    logic        vram32_we;

    int errors = 0;
    int checks = 0;

    vram_write_scheduler_if #(.DEPTH(DEPTH)) cpu ();

    vram_write_scheduler #(
        .DEPTH(DEPTH), .VSTART(VSTART), .VLINES(VLINES),
        .WIN_START(WIN_START), .WIN_END(WIN_END)
    ) dut (
        .clkPixel(clkPixel),
        .reset(reset),
        .h_count(h_count),
        .v_count(v_count),
        .cpu(cpu),
        .render_vram8_addr(render_vram8_addr),
        .render_vram32_addr(render_vram32_addr),
        .vram8_addr(vram8_addr),
        .vram8_d(vram8_d),
        .vram8_we(vram8_we),
        .vram32_addr(vram32_addr),
        .vram32_d(vram32_d),
        .vram32_we(vram32_we)
    );

    always #5 clkPixel = ~clkPixel;

    // Reference model: a plain queue of pending writes plus a flush flag.
    logic [46:0] q[$];
    bit          pend = 1'b0;
    bit          exp_commit, exp_ready, exp_done, do_push;
    int          exp_level;
    logic [46:0] exp_head;

    function automatic bit slot_m(int h, int v);
        bit blank;
        blank = (v < VSTART - 1) || (v >= VSTART - 1 + VLINES);
`ifdef VRAM_VBLANK_ONLY_EN
        return blank && (h >= WIN_START);
`else
        if (blank) return h >= WIN_START;
        return (h >= WIN_START) && (h < WIN_END);
`endif
    endfunction

    always @(negedge clkPixel) begin
        exp_level  = q.size();
        exp_ready  = (q.size() < DEPTH);
        exp_head   = (q.size() > 0) ? q[0] : '0;
        exp_commit = !reset && slot_m(int'(h_count), int'(v_count)) && (q.size() > 0);
        exp_done   = !reset && pend && (q.size() == 0) && !(cpu.cpu_valid && exp_ready);
    end

    always @(posedge clkPixel) begin
        if (reset) begin
            q.delete();
            pend = 1'b0;
        end else begin
            do_push = cpu.cpu_valid && (q.size() < DEPTH);
            if (exp_commit) void'(q.pop_front());
            if (do_push) q.push_back({cpu.cpu_sel, cpu.cpu_addr, cpu.cpu_data});
            pend = (pend || cpu.cpu_flush) && !exp_done;
        end
    end

    task automatic next_cycle();
        @(posedge clkPixel);
        #1;
    endtask

    task automatic sample();
        @(negedge clkPixel);
        #1;
    endtask

    task automatic push(input logic sel, input logic [13:0] addr, input logic [31:0] data);
        cpu.cpu_valid = 1'b1;
        cpu.cpu_sel   = sel;
        cpu.cpu_addr  = addr;
        cpu.cpu_data  = data;
        next_cycle();
        cpu.cpu_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; v_count = 12'd10; h_count = 12'd10;
        next_cycle();
        sample();
        checks++; if (cpu.cpu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", cpu.cpu_ready); end
        checks++; if (cpu.flush_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", cpu.flush_done); end
        checks++; if (cpu.fifo_level !== LW'(0)) begin errors++; $display("FAIL reset_level got %0d want 0", cpu.fifo_level); end
        checks++; if ({vram8_we, vram32_we} !== 2'b00) begin errors++; $display("FAIL reset_we got %b want 00", {vram8_we, vram32_we}); end
        checks++; if (vram8_d !== 8'h0 || vram32_d !== 32'h0) begin errors++; $display("FAIL reset_data got %h/%h want 0/0", vram8_d, vram32_d); end
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_line_commit();
        int ea[3] = '{8192, 2048, 10};
        int ed[3] = '{'h05, 'h11, 'h22};
        v_count = 12'd200; h_count = 12'd500;
        for (int i = 0; i < 3; i++) push(1'b0, 14'(ea[i]), 32'(ed[i]));
        sample();
        checks++; if (cpu.fifo_level !== LW'(3)) begin errors++; $display("FAIL line_level0 got %0d want 3", cpu.fifo_level); end
        checks++; if (vram8_we !== 1'b0) begin errors++; $display("FAIL line_early_we got %0b want 0", vram8_we); end
        next_cycle();
        v_count = 12'd201;
        for (int hh = 0; hh < 10; hh++) begin
            bit ew;
            int el;
            h_count = 12'(hh);
            render_vram8_addr = 14'($urandom);
            ew = (hh >= 4) && (hh <= 6);
            el = (hh <= 4) ? 3 : ((hh >= 7) ? 0 : 7 - hh);
            sample();
            checks++; if (vram8_we !== ew || vram32_we !== 1'b0) begin errors++; $display("FAIL line_we h=%0d got %0b%0b want %0b0", hh, vram8_we, vram32_we, ew); end
            checks++; if (cpu.fifo_level !== LW'(el)) begin errors++; $display("FAIL line_level h=%0d got %0d want %0d", hh, cpu.fifo_level, el); end
            if (ew) begin
                checks++; if (vram8_addr !== 14'(ea[hh-4]) || vram8_d !== 8'(ed[hh-4])) begin errors++; $display("FAIL line_entry h=%0d got %0d/%h want %0d/%h", hh, vram8_addr, vram8_d, ea[hh-4], ed[hh-4]); end
            end else begin
                checks++; if (vram8_addr !== render_vram8_addr) begin errors++; $display("FAIL line_mux h=%0d got %0d want %0d", hh, vram8_addr, render_vram8_addr); end
            end
            next_cycle();
        end
    endtask

    task automatic test_full();
        v_count = 12'd200; h_count = 12'd500;
        for (int i = 0; i < 16; i++) push(1'b0, 14'(i), 32'(i));
        sample();
        checks++; if (cpu.cpu_ready !== 1'b0 || cpu.fifo_level !== LW'(16)) begin errors++; $display("FAIL full_state got rdy=%0b lvl=%0d want 0/16", cpu.cpu_ready, cpu.fifo_level); end
        next_cycle();
        cpu.cpu_valid = 1'b1; cpu.cpu_sel = 1'b0; cpu.cpu_addr = 14'd100; cpu.cpu_data = 32'hAA;
        next_cycle();
        sample();
        checks++; if (cpu.fifo_level !== LW'(16)) begin errors++; $display("FAIL full_nopush got %0d want 16", cpu.fifo_level); end
        next_cycle();
        h_count = 12'd4;
        sample();
        checks++; if (cpu.cpu_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready got %0b want 0", cpu.cpu_ready); end
        checks++; if (vram8_we !== 1'b1 || vram8_d !== 8'h00) begin errors++; $display("FAIL full_pop got we=%0b d=%h want 1/00", vram8_we, vram8_d); end
        next_cycle();
        cpu.cpu_valid = 1'b0;
        for (int j = 1; j < 16; j++) begin
            sample();
            if (j == 1) begin
                checks++; if (cpu.cpu_ready !== 1'b1 || cpu.fifo_level !== LW'(15)) begin errors++; $display("FAIL full_after got rdy=%0b lvl=%0d want 1/15", cpu.cpu_ready, cpu.fifo_level); end
            end
            checks++; if (vram8_we !== 1'b1 || vram8_d !== 8'(j)) begin errors++; $display("FAIL full_order j=%0d got we=%0b d=%h want 1/%h", j, vram8_we, vram8_d, 8'(j)); end
            next_cycle();
        end
        sample();
        checks++; if (vram8_we !== 1'b0 || cpu.fifo_level !== LW'(0)) begin errors++; $display("FAIL full_end got we=%0b lvl=%0d want 0/0", vram8_we, cpu.fifo_level); end
        next_cycle();
    endtask

    task automatic test_boundary();
        int expn = 0;
        int seen = 0;
        int seen_line = 0;
        v_count = 12'd200; h_count = 12'd500;
        for (int i = 0; i < 10; i++) push(1'b0, 14'(100 + i), 32'(8'h30 + i));
        for (int k = 0; k < 24; k++) begin
            int hh;
            bit ew;
            hh = (k < 12) ? 120 + k : k - 12;
            v_count = (k < 12) ? 12'd200 : 12'd201;
            h_count = 12'(hh);
            render_vram8_addr = 14'($urandom);
            ew = (hh >= 4) && (hh < 124) && (expn < 10);
            sample();
            checks++; if (vram8_we !== ew) begin errors++; $display("FAIL bound_we h=%0d got %0b want %0b", hh, vram8_we, ew); end
            if (ew) begin
                checks++; if (vram8_addr !== 14'(100 + expn) || vram8_d !== 8'(8'h30 + expn)) begin errors++; $display("FAIL bound_entry h=%0d got %0d/%h want %0d/%h", hh, vram8_addr, vram8_d, 100 + expn, 8'h30 + expn); end
                expn++;
            end else begin
                checks++; if (vram8_addr !== render_vram8_addr) begin errors++; $display("FAIL bound_mux h=%0d got %0d want %0d", hh, vram8_addr, render_vram8_addr); end
            end
            if (vram8_we === 1'b1) begin
                seen++;
                if (k < 12) seen_line++;
            end
            next_cycle();
        end
        checks++; if (seen_line != 4) begin errors++; $display("FAIL bound_line_commits got %0d want 4", seen_line); end
        checks++; if (seen != 10) begin errors++; $display("FAIL bound_total_commits got %0d want 10", seen); end
    endtask

    task automatic test_mixed();
        v_count = 12'd10; h_count = 12'd1;
        push(1'b1, 14'd1024, 32'hE0E0E0E0);
        push(1'b0, 14'd3, 32'h7F);
        h_count = 12'd4;
        for (int c = 0; c < 4; c++) begin
            render_vram8_addr  = 14'($urandom);
            render_vram32_addr = 11'($urandom);
            sample();
            checks++; if (vram8_we === 1'b1 && vram32_we === 1'b1) begin errors++; $display("FAIL mixed_both c=%0d got 11 want not both", c); end
            if (c == 0) begin
                checks++; if (vram32_we !== 1'b1 || vram32_addr !== 11'd1024 || vram32_d !== 32'hE0E0E0E0) begin errors++; $display("FAIL mixed_v32 got we=%0b a=%0d d=%h want 1/1024/e0e0e0e0", vram32_we, vram32_addr, vram32_d); end
                checks++; if (vram8_we !== 1'b0 || vram8_addr !== render_vram8_addr) begin errors++; $display("FAIL mixed_v8idle got we=%0b a=%0d want 0/%0d", vram8_we, vram8_addr, render_vram8_addr); end
            end else if (c == 1) begin
                checks++; if (vram8_we !== 1'b1 || vram8_addr !== 14'd3 || vram8_d !== 8'h7F) begin errors++; $display("FAIL mixed_v8 got we=%0b a=%0d d=%h want 1/3/7f", vram8_we, vram8_addr, vram8_d); end
                checks++; if (vram32_we !== 1'b0 || vram32_addr !== render_vram32_addr) begin errors++; $display("FAIL mixed_v32idle got we=%0b a=%0d want 0/%0d", vram32_we, vram32_addr, render_vram32_addr); end
            end else begin
                checks++; if ({vram8_we, vram32_we} !== 2'b00) begin errors++; $display("FAIL mixed_tail c=%0d got %b want 00", c, {vram8_we, vram32_we}); end
            end
            next_cycle();
        end
    endtask

    task automatic test_flush();
        int pulses = 0;
        v_count = 12'd200;
        for (int hh = 50; hh < 59; hh++) begin
            h_count = 12'(hh);
            cpu.cpu_valid = (hh == 50) || (hh == 51);
            cpu.cpu_sel   = 1'b0;
            cpu.cpu_addr  = 14'(hh - 43);
            cpu.cpu_data  = 32'(hh - 9);
            cpu.cpu_flush = (hh == 50) || (hh == 51);
            sample();
            checks++; if (cpu.flush_done !== (hh == 53)) begin errors++; $display("FAIL flush_done h=%0d got %0b want %0b", hh, cpu.flush_done, hh == 53); end
            checks++; if (vram8_we !== (hh == 51 || hh == 52)) begin errors++; $display("FAIL flush_we h=%0d got %0b want %0b", hh, vram8_we, hh == 51 || hh == 52); end
            if (cpu.flush_done === 1'b1) pulses++;
            next_cycle();
        end
        cpu.cpu_valid = 1'b0; cpu.cpu_flush = 1'b0;
        checks++; if (pulses != 1) begin errors++; $display("FAIL flush_pulses got %0d want 1", pulses); end
        for (int c = 0; c < 3; c++) begin
            cpu.cpu_flush = (c == 0);
            sample();
            checks++; if (cpu.flush_done !== (c == 1)) begin errors++; $display("FAIL flush_empty c=%0d got %0b want %0b", c, cpu.flush_done, c == 1); end
            next_cycle();
        end
        cpu.cpu_flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        v_count = 12'd200; h_count = 12'd500;
        for (int i = 0; i < 5; i++) push(1'b0, 14'(200 + i), 32'(8'h60 + i));
        h_count = 12'd4;
        sample();
        checks++; if (vram8_we !== 1'b1 || vram8_addr !== 14'd200) begin errors++; $display("FAIL rmid_first got we=%0b a=%0d want 1/200", vram8_we, vram8_addr); end
        next_cycle();
        reset = 1'b1; h_count = 12'd5;
        sample();
        checks++; if ({vram8_we, vram32_we} !== 2'b00) begin errors++; $display("FAIL rmid_we got %b want 00", {vram8_we, vram32_we}); end
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            h_count = 12'(6 + c);
            sample();
            checks++; if ({vram8_we, vram32_we} !== 2'b00 || cpu.fifo_level !== LW'(0) || cpu.cpu_ready !== 1'b1) begin
                errors++; $display("FAIL rmid_after c=%0d got we=%b lvl=%0d rdy=%0b want 00/0/1", c, {vram8_we, vram32_we}, cpu.fifo_level, cpu.cpu_ready);
            end
            next_cycle();
        end
    endtask

    task automatic test_random();
        int vs[7] = '{10, 84, 85, 200, 484, 485, 1000};
        logic [13:0] ea8;
        logic [10:0] ea32;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 3))
                0: h_count = 12'($urandom_range(0, 8));
                1: h_count = 12'($urandom_range(118, 130));
                2: h_count = 12'($urandom_range(0, 4095));
                default: h_count = 12'd500;
            endcase
            v_count = 12'(vs[$urandom_range(0, 6)]);
            reset = ($urandom_range(0, 299) == 0);
            cpu.cpu_valid = ($urandom_range(0, 9) < 6);
            cpu.cpu_sel   = 1'($urandom);
            cpu.cpu_addr  = 14'($urandom);
            cpu.cpu_data  = $urandom;
            cpu.cpu_flush = ($urandom_range(0, 19) == 0);
            render_vram8_addr  = 14'($urandom);
            render_vram32_addr = 11'($urandom);
            sample();
            ea8  = (exp_commit && !exp_head[46]) ? exp_head[45:32] : render_vram8_addr;
            ea32 = (exp_commit && exp_head[46]) ? exp_head[42:32] : render_vram32_addr;
            checks++; if (cpu.cpu_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready n=%0d got %0b want %0b", n, cpu.cpu_ready, exp_ready); end
            checks++; if (cpu.fifo_level !== LW'(exp_level)) begin errors++; $display("FAIL rnd_level n=%0d got %0d want %0d", n, cpu.fifo_level, exp_level); end
            checks++; if (cpu.flush_done !== exp_done) begin errors++; $display("FAIL rnd_done n=%0d got %0b want %0b", n, cpu.flush_done, exp_done); end
            checks++; if (vram8_we !== (exp_commit && !exp_head[46]) || vram32_we !== (exp_commit && exp_head[46])) begin
                errors++; $display("FAIL rnd_we n=%0d got %0b%0b want %0b%0b", n, vram8_we, vram32_we, exp_commit && !exp_head[46], exp_commit && exp_head[46]);
            end
            checks++; if (vram8_addr !== ea8 || vram32_addr !== ea32) begin errors++; $display("FAIL rnd_addr n=%0d got %0d/%0d want %0d/%0d", n, vram8_addr, vram32_addr, ea8, ea32); end
            if (exp_commit) begin
                checks++;
                if (exp_head[46] ? (vram32_d !== exp_head[31:0]) : (vram8_d !== exp_head[7:0])) begin
                    errors++; $display("FAIL rnd_data n=%0d got %h/%h want %h", n, vram8_d, vram32_d, exp_head[31:0]);
                end
            end
            next_cycle();
        end
        reset = 1'b0;
        cpu.cpu_valid = 1'b0;
        cpu.cpu_flush = 1'b0;
    endtask

    initial begin
        cpu.cpu_valid = 1'b0;
        cpu.cpu_sel   = 1'b0;
        cpu.cpu_addr  = '0;
        cpu.cpu_data  = '0;
        cpu.cpu_flush = 1'b0;
        test_reset();
        test_line_commit();
        do_reset();
        test_full();
        do_reset();
        test_boundary();
        do_reset();
        test_mixed();
        do_reset();
        test_flush();
        do_reset();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
